uart_cmd_master: RTL and testbench
==================================

UART_CMD_MASTER -- requirements
Module: uart_cmd_master

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 32'd1_000_000, response wait limit in clk cycles.
REQ-002 Parameter SOF_CMD, default 8'h55, command frame start byte.
REQ-003 Parameter SOF_RSP, default 8'hAA, response frame start byte.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst_n  in  1  synchronous, active-low reset.
REQ-006 job_valid  in  1  job request.
REQ-007 job_target  in  32  target word to send.
REQ-008 job_ready  out  1  high only in IDLE.
REQ-009 tx_data  out  8  byte to UART transmitter.
REQ-010 new_tx_data  out  1  one-cycle strobe qualifying tx_data.
REQ-011 tx_busy  in  1  UART transmitter busy.
REQ-012 rx_data  in  8  byte from UART receiver.
REQ-013 new_rx_data  in  1  one-cycle strobe qualifying rx_data.
REQ-014 rsp_valid  out  1  one-cycle pulse: good response received.
REQ-015 rsp_nonce  out  32  nonce from last good response; held until next good response.
REQ-016 rsp_timeout  out  1  one-cycle pulse: no good response within TIMEOUT_CYCLES.
REQ-017 rsp_chk_err  out  1  one-cycle pulse: response frame with bad checksum discarded.
REQ-018 busy  out  1  high whenever state is not IDLE.

Function
REQ-019 Command frame SHALL be 6 bytes: SOF_CMD, target[31:24], [23:16], [15:8], [7:0], XOR of the four target bytes.
REQ-020 Response frame SHALL be 6 bytes: SOF_RSP, nonce bytes MSB first, XOR of the four nonce bytes.
REQ-021 Main FSM states SHALL be IDLE, SEND, WAIT_RSP; job accepted on job_valid&job_ready, job_target captured, IDLE->SEND.
REQ-022 In SEND a byte SHALL be issued only when tx_busy=0 and new_tx_data was low in the previous cycle; first strobe no earlier than acceptance cycle +1.
REQ-023 After the 6th strobe, SEND->WAIT_RSP and the timeout counter SHALL clear to 0.
REQ-024 In WAIT_RSP the counter SHALL increment each cycle; reaching TIMEOUT_CYCLES-1 without a good frame -> rsp_timeout pulse, ->IDLE.
REQ-025 Response deframer states SHALL be HUNT, B0..B3, CHK; it advances only on new_rx_data, otherwise holds.
REQ-026 In HUNT, bytes other than SOF_RSP SHALL be discarded silently.
REQ-027 A byte equal to SOF_RSP in B0..B3 or CHK SHALL be treated as data, not resync.
REQ-028 CHK match in WAIT_RSP -> rsp_nonce updated, rsp_valid pulse next cycle, ->IDLE; mismatch -> rsp_chk_err pulse, deframer->HUNT, main FSM stays in WAIT_RSP.
REQ-029 Deframer SHALL be held in HUNT and rx bytes ignored while main FSM is IDLE or SEND.
REQ-030 If good CHK and timeout coincide in one cycle, rsp_valid SHALL win; no rsp_timeout pulse.
REQ-031 job_valid outside IDLE SHALL be ignored; no queueing.
REQ-032 rsp_valid, rsp_timeout, rsp_chk_err SHALL be mutually exclusive per cycle.

Reset
REQ-033 rst_n=0 SHALL force main FSM IDLE and deframer HUNT, and clear the counter; on the same edge, job_ready=1 and all other outputs=0 (rsp_nonce=0, tx_data=0).
REQ-034 Reset mid-frame SHALL abandon the frame without emitting any pulse; a partial TX frame is not completed.

Structure
REQ-035 Package uart_proto_pkg SHALL hold SOF constants, frame length 6, and main/deframer state enums.
REQ-036 Deframer SHALL be sub-module uart_rsp_deframer (rx strobe in; nonce, good, bad out; enable from main FSM).

Verification
REQ-037 Job target 32'h1234_5678, tx_busy low except 10 cycles after each strobe -> tx bytes 55 12 34 56 78 08, strobes spaced >=11 cycles.
REQ-038 After REQ-037, rx AA DE AD BE EF 22 -> rsp_valid one cycle, rsp_nonce=32'hDEAD_BEEF, job_ready=1.
REQ-039 rx AA 00 00 00 01 00 -> rsp_chk_err one cycle, still busy; then 11 AA 00 00 00 01 01 -> rsp_valid, nonce=1.
REQ-040 TIMEOUT_CYCLES=100, no rx -> rsp_timeout exactly 100 cycles after WAIT_RSP entry, then IDLE.
REQ-041 rst_n low after 3rd tx byte for one cycle -> no further strobes, all outputs at reset values, new job accepted next cycle.
REQ-042 Good CHK byte arriving in the timeout cycle -> rsp_valid only; job_valid pulses during SEND ignored.

Source files
------------

// File: rtl/uart_proto_pkg.sv
// Shared protocol definitions for the UART command master: frame markers,
// frame length, state encodings and the byte-wise XOR checksum helper.
package uart_proto_pkg;

    localparam logic [7:0] SOF_CMD_DEFAULT = 8'h55;
    localparam logic [7:0] SOF_RSP_DEFAULT = 8'hAA;
    localparam int         FRAME_LEN       = 6;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT_RSP
    } main_state_t;

    typedef enum logic [2:0] {
        DF_HUNT,
        DF_B0,
        DF_B1,
        DF_B2,
        DF_B3,
        DF_CHK
    } deframer_state_t;

    // Checksum carried in both frame types: XOR of the four payload bytes.
    function automatic logic [7:0] xor_bytes(input logic [31:0] word);
        return word[31:24] ^ word[23:16] ^ word[15:8] ^ word[7:0];
    endfunction

    // Byte idx of a command frame: start byte, payload MSB first, checksum.
    function automatic logic [7:0] cmd_byte(input logic [7:0]  sof,
                                            input logic [31:0] word,
                                            input logic [2:0]  idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = sof;
            3'd1:    b = word[31:24];
            3'd2:    b = word[23:16];
            3'd3:    b = word[15:8];
            3'd4:    b = word[7:0];
            default: b = xor_bytes(word);
        endcase
        return b;
    endfunction

endpackage

// File: rtl/uart_rsp_deframer.sv
// Response deframer: hunts for the response start byte, collects four nonce
// bytes MSB first and checks the XOR byte. good/bad are single-cycle flags
// raised in the cycle the checksum byte is presented.
module uart_rsp_deframer
    import uart_proto_pkg::*;
#(
    parameter logic [7:0] SOF_RSP = SOF_RSP_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [7:0]  rx_data,
    input  logic        new_rx_data,
    output logic [31:0] nonce,
    output logic        good,
    output logic        bad
);

    deframer_state_t state, state_next;
    logic [31:0]     nonce_q, nonce_next;

    assign nonce = nonce_q;

    // State and nonce shift register; disabled means parked in HUNT.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= DF_HUNT;
            nonce_q <= '0;
        end else begin
            state   <= state_next;
            nonce_q <= nonce_next;
        end
    end

    // Advance only on a received byte; inside a frame every byte is data,
    // so a start-byte value there never causes a resync.
    always_comb begin
        state_next = state;
        nonce_next = nonce_q;
        good       = 1'b0;
        bad        = 1'b0;
        if (!enable) begin
            state_next = DF_HUNT;
        end else if (new_rx_data) begin
            case (state)
                DF_HUNT: begin
                    if (rx_data == SOF_RSP) begin
                        state_next = DF_B0;
                    end
                end
                DF_B0: begin
                    nonce_next = {nonce_q[23:0], rx_data};
                    state_next = DF_B1;
                end
                DF_B1: begin
                    nonce_next = {nonce_q[23:0], rx_data};
                    state_next = DF_B2;
                end
                DF_B2: begin
                    nonce_next = {nonce_q[23:0], rx_data};
                    state_next = DF_B3;
                end
                DF_B3: begin
                    nonce_next = {nonce_q[23:0], rx_data};
                    state_next = DF_CHK;
                end
                DF_CHK: begin
                    if (rx_data == xor_bytes(nonce_q)) begin
                        good = 1'b1;
                    end else begin
                        bad = 1'b1;
                    end
                    state_next = DF_HUNT;
                end
                default: state_next = DF_HUNT;
            endcase
        end
    end

endmodule

// File: rtl/uart_cmd_master.sv
// UART command master: takes a 32-bit job, sends it as a 6-byte command
// frame paced by the transmitter, then waits for a checksummed response
// frame carrying a nonce, reporting success, checksum error or timeout.
module uart_cmd_master
    import uart_proto_pkg::*;
#(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd1_000_000,
    parameter logic [7:0]  SOF_CMD        = SOF_CMD_DEFAULT,
    parameter logic [7:0]  SOF_RSP        = SOF_RSP_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        job_valid,
    input  logic [31:0] job_target,
    output logic        job_ready,
    output logic [7:0]  tx_data,
    output logic        new_tx_data,
    input  logic        tx_busy,
    input  logic [7:0]  rx_data,
    input  logic        new_rx_data,
    output logic        rsp_valid,
    output logic [31:0] rsp_nonce,
    output logic        rsp_timeout,
    output logic        rsp_chk_err,
    output logic        busy
);

    localparam logic [2:0] LAST_IDX = 3'(FRAME_LEN - 1);

    main_state_t state, state_next;
    logic [31:0] target_q, target_next;
    logic [2:0]  byte_idx, idx_next;
    logic [31:0] count, count_next;
    logic [7:0]  tx_data_next;
    logic        new_tx_next;
    logic        valid_next, timeout_next, chk_err_next;
    logic [31:0] nonce_next;
    logic [31:0] df_nonce;
    logic        df_good, df_bad;

    assign job_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);

    uart_rsp_deframer #(
        .SOF_RSP(SOF_RSP)
    ) u_deframer (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (state == ST_WAIT_RSP),
        .rx_data    (rx_data),
        .new_rx_data(new_rx_data),
        .nonce      (df_nonce),
        .good       (df_good),
        .bad        (df_bad)
    );

    // All registered state; reset drops any frame in flight without pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            target_q    <= '0;
            byte_idx    <= '0;
            count       <= '0;
            tx_data     <= '0;
            new_tx_data <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_timeout <= 1'b0;
            rsp_chk_err <= 1'b0;
            rsp_nonce   <= '0;
        end else begin
            state       <= state_next;
            target_q    <= target_next;
            byte_idx    <= idx_next;
            count       <= count_next;
            tx_data     <= tx_data_next;
            new_tx_data <= new_tx_next;
            rsp_valid   <= valid_next;
            rsp_timeout <= timeout_next;
            rsp_chk_err <= chk_err_next;
            rsp_nonce   <= nonce_next;
        end
    end

    // Next state and datapath; a good frame beats a same-cycle timeout, and
    // a timeout beats a same-cycle checksum error so pulses never overlap.
    always_comb begin
        state_next   = state;
        target_next  = target_q;
        idx_next     = byte_idx;
        count_next   = count;
        tx_data_next = tx_data;
        new_tx_next  = 1'b0;
        valid_next   = 1'b0;
        timeout_next = 1'b0;
        chk_err_next = 1'b0;
        nonce_next   = rsp_nonce;
        case (state)
            ST_IDLE: begin
                if (job_valid && job_ready) begin
                    target_next = job_target;
                    idx_next    = '0;
                    state_next  = ST_SEND;
                end
            end
            ST_SEND: begin
                if (!tx_busy && !new_tx_data) begin
                    tx_data_next = cmd_byte(SOF_CMD, target_q, byte_idx);
                    new_tx_next  = 1'b1;
                    idx_next     = byte_idx + 3'd1;
                    if (byte_idx == LAST_IDX) begin
                        count_next = '0;
                        state_next = ST_WAIT_RSP;
                    end
                end
            end
            ST_WAIT_RSP: begin
                count_next = count + 32'd1;
                if (df_good) begin
                    nonce_next = df_nonce;
                    valid_next = 1'b1;
                    state_next = ST_IDLE;
                end else if (count == TIMEOUT_CYCLES - 32'd1) begin
                    timeout_next = 1'b1;
                    state_next   = ST_IDLE;
                end else if (df_bad) begin
                    chk_err_next = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_cmd_master.sv
// Self-checking bench for uart_cmd_master: a table of directed jobs, a reset
// sequence, and randomized jobs checked against a byte-stream reference model.
module tb_uart_cmd_master;

    localparam int TMO = 100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        job_valid;
    logic [31:0] job_target;
    logic        job_ready;
    logic [7:0]  tx_data;
    logic        new_tx_data;
    logic        tx_busy = 1'b0;
    logic [7:0]  rx_data;
    logic        new_rx_data;
    logic        rsp_valid;
    logic [31:0] rsp_nonce;
    logic        rsp_timeout;
    logic        rsp_chk_err;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0] tx_bytes[$];
    int         tx_cycles[$];
    int         busy_cnt = 0;
    logic [7:0] rx_stream[$];
    logic [31:0] last_nonce = '0;

    int n_valid = 0, n_timeout = 0, n_chkerr = 0, n_chkerr_idle = 0;
    int n_overlap = 0, n_long = 0;
    int valid_cyc = 0, timeout_cyc = 0;
    logic prev_v = 1'b0, prev_t = 1'b0, prev_c = 1'b0;

    logic [7:0] noise [4] = '{8'hAA, 8'h11, 8'h22, 8'h33};

    logic [7:0] rx_pool [38] = '{
        8'hAA, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22,
        8'hAA, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h11,
        8'hAA, 8'h00, 8'h00, 8'h00, 8'h01, 8'h01,
        8'h13, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'h00,
        8'hAA, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04,
        8'hAA, 8'h05, 8'h06, 8'h07, 8'h08, 8'h0C
    };

    typedef struct {
        logic [31:0] target;
        logic [7:0]  tx_chk;
        int          rx_off;
        int          rx_len;
        int          rx_start;
        bit          rx_in_send;
        bit          exp_good;
        logic [31:0] exp_nonce;
        int          exp_chkerr;
        int          exp_evt;
    } vec_t;

    vec_t vecs [7];

    uart_cmd_master #(
        .TIMEOUT_CYCLES(32'(TMO)),
        .SOF_CMD       (8'h55),
        .SOF_RSP       (8'hAA)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .job_valid  (job_valid),
        .job_target (job_target),
        .job_ready  (job_ready),
        .tx_data    (tx_data),
        .new_tx_data(new_tx_data),
        .tx_busy    (tx_busy),
        .rx_data    (rx_data),
        .new_rx_data(new_rx_data),
        .rsp_valid  (rsp_valid),
        .rsp_nonce  (rsp_nonce),
        .rsp_timeout(rsp_timeout),
        .rsp_chk_err(rsp_chk_err),
        .busy       (busy)
    );

    // Free-running clock and cycle stamp.
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // UART transmitter stand-in: records each strobed byte and stays busy
    // for 10 cycles after it.
    always @(negedge clk) begin
        if (new_tx_data) begin
            tx_bytes.push_back(tx_data);
            tx_cycles.push_back(cyc);
            busy_cnt = 10;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
        end
        tx_busy = (busy_cnt != 0);
    end

    // Response pulse monitor: counts, timestamps, overlap and width faults.
    always @(negedge clk) begin
        if (rsp_valid) begin
            n_valid++;
            valid_cyc = cyc;
        end
        if (rsp_timeout) begin
            n_timeout++;
            timeout_cyc = cyc;
        end
        if (rsp_chk_err) begin
            n_chkerr++;
            if (!busy) n_chkerr_idle++;
        end
        if (int'(rsp_valid) + int'(rsp_timeout) + int'(rsp_chk_err) > 1) n_overlap++;
        if ((rsp_valid && prev_v) || (rsp_timeout && prev_t) || (rsp_chk_err && prev_c)) n_long++;
        prev_v = rsp_valid;
        prev_t = rsp_timeout;
        prev_c = rsp_chk_err;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] xor4(input logic [31:0] w);
        return w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
    endfunction

    // Reference model: scan the received byte stream for start bytes, take
    // the following five bytes as a frame and judge it by its checksum.
    task automatic ref_model(output bit good, output logic [31:0] nonce, output int nerr);
        int i;
        logic [31:0] n;
        i = 0;
        good = 1'b0;
        nonce = '0;
        nerr = 0;
        while (i < rx_stream.size() && !good) begin
            if (rx_stream[i] == 8'hAA && i + 5 < rx_stream.size()) begin
                n = {rx_stream[i+1], rx_stream[i+2], rx_stream[i+3], rx_stream[i+4]};
                if (rx_stream[i+5] == xor4(n)) begin
                    good = 1'b1;
                    nonce = n;
                end else begin
                    nerr++;
                end
                i += 6;
            end else begin
                i++;
            end
        end
    endtask

    task automatic send_rx(input logic [7:0] b);
        rx_data = b;
        new_rx_data = 1'b1;
        tick();
        new_rx_data = 1'b0;
        tick();
    endtask

    task automatic push_frame(input logic [31:0] n, input bit corrupt);
        logic [7:0] c;
        c = xor4(n);
        if (corrupt) c = c ^ 8'(32'($urandom_range(1, 255)));
        rx_stream.push_back(8'hAA);
        rx_stream.push_back(n[31:24]);
        rx_stream.push_back(n[23:16]);
        rx_stream.push_back(n[15:8]);
        rx_stream.push_back(n[7:0]);
        rx_stream.push_back(c);
    endtask

    // One full job: accept, watch the command frame, play rx_stream into the
    // response window starting rx_start cycles after WAIT_RSP entry, check.
    task automatic apply_stimulus(input string name, input logic [31:0] target,
                                  input logic [7:0] exp_chk, input int rx_start,
                                  input bit rx_in_send, input bit exp_good,
                                  input logic [31:0] exp_nonce, input int exp_chkerr,
                                  input int exp_evt);
        int guard;
        int w;
        int accept_cyc;
        logic [7:0] e [6];
        tx_bytes.delete();
        tx_cycles.delete();
        n_valid = 0;
        n_timeout = 0;
        n_chkerr = 0;
        n_chkerr_idle = 0;
        guard = 0;
        while (!job_ready && guard < 500) begin
            tick();
            guard++;
        end
        check_output({name, " job_ready"}, 64'(job_ready), 64'd1);
        job_target = target;
        job_valid = 1'b1;
        accept_cyc = cyc;
        tick();
        job_valid = 1'b0;
        job_target = $urandom;
        guard = 0;
        while (tx_bytes.size() < 6 && guard < 200) begin
            job_valid = (guard == 4 || guard == 30);
            if (rx_in_send && guard < 8) begin
                rx_data = noise[guard / 2];
                new_rx_data = (guard % 2 == 0);
            end else begin
                new_rx_data = 1'b0;
            end
            tick();
            guard++;
        end
        job_valid = 1'b0;
        new_rx_data = 1'b0;
        check_output({name, " strobe count"}, 64'(tx_bytes.size()), 64'd6);
        w = cyc;
        if (tx_bytes.size() >= 6) begin
            e[0] = 8'h55;
            e[1] = 8'((target >> 24) & 32'hFF);
            e[2] = 8'((target >> 16) & 32'hFF);
            e[3] = 8'((target >> 8) & 32'hFF);
            e[4] = 8'(target & 32'hFF);
            e[5] = exp_chk;
            for (int i = 0; i < 6; i++) begin
                check_output($sformatf("%s tx byte %0d", name, i), 64'(tx_bytes[i]), 64'(e[i]));
            end
            check_output({name, " first strobe after accept"}, 64'(tx_cycles[0] > accept_cyc), 64'd1);
            for (int i = 1; i < 6; i++) begin
                check_output($sformatf("%s strobe gap %0d>=11", name, i),
                             64'(tx_cycles[i] - tx_cycles[i-1] >= 11), 64'd1);
            end
            w = tx_cycles[5];
        end
        guard = 0;
        while (cyc < w + rx_start && guard < 300) begin
            tick();
            guard++;
        end
        foreach (rx_stream[k]) send_rx(rx_stream[k]);
        guard = 0;
        while (n_valid == 0 && n_timeout == 0 && guard < 300) begin
            tick();
            guard++;
        end
        repeat (3) tick();
        check_output({name, " rsp_valid pulses"}, 64'(n_valid), exp_good ? 64'd1 : 64'd0);
        check_output({name, " rsp_timeout pulses"}, 64'(n_timeout), exp_good ? 64'd0 : 64'd1);
        check_output({name, " rsp_chk_err pulses"}, 64'(n_chkerr), 64'(exp_chkerr));
        check_output({name, " chk_err while idle"}, 64'(n_chkerr_idle), 64'd0);
        check_output({name, " rsp_nonce"}, 64'(rsp_nonce), 64'(exp_nonce));
        if (exp_evt >= 0) begin
            check_output({name, " event cycle"},
                         64'(exp_good ? valid_cyc - w : timeout_cyc - w), 64'(exp_evt));
        end
        check_output({name, " back to idle"}, {62'd0, job_ready, busy}, 64'b10);
        check_output({name, " no extra strobes"}, 64'(tx_bytes.size()), 64'd6);
    endtask

    initial begin
        bit          m_good;
        logic [31:0] m_nonce;
        int          m_err;
        int          guard;
        logic [31:0] t;

        vecs[0] = '{32'h1234_5678, 8'h08,  0,  6,  2, 1'b0, 1'b1, 32'hDEAD_BEEF, 1,  -1};
        vecs[0].exp_chkerr = 0;
        vecs[1] = '{32'h0000_0001, 8'h01,  6, 13,  2, 1'b0, 1'b1, 32'h0000_0001, 1,  -1};
        vecs[2] = '{32'hFFFF_FFFF, 8'h00,  0,  6,  2, 1'b1, 1'b1, 32'hDEAD_BEEF, 0,  -1};
        vecs[3] = '{32'hA5A5_5A5A, 8'h00,  0,  0,  2, 1'b0, 1'b0, 32'hDEAD_BEEF, 0, TMO};
        vecs[4] = '{32'h0BAD_F00D, 8'h5B, 19,  7,  2, 1'b0, 1'b1, 32'hAAAA_AAAA, 0,  -1};
        vecs[5] = '{32'h1357_9BDF, 8'h00, 26,  6, 89, 1'b0, 1'b1, 32'h0102_0304, 0, TMO};
        vecs[6] = '{32'h2468_ACE0, 8'h00, 32,  6, 90, 1'b0, 1'b0, 32'h0102_0304, 0, TMO};

        rst_n = 1'b0;
        job_valid = 1'b0;
        job_target = '0;
        rx_data = '0;
        new_rx_data = 1'b0;
        repeat (3) tick();
        check_output("reset flags", {58'd0, job_ready, busy, new_tx_data, rsp_valid, rsp_timeout, rsp_chk_err},
                     64'b100000);
        check_output("reset tx_data", 64'(tx_data), 64'd0);
        check_output("reset rsp_nonce", 64'(rsp_nonce), 64'd0);
        rst_n = 1'b1;
        tick();

        for (int v = 0; v < 7; v++) begin
            rx_stream.delete();
            for (int k = 0; k < vecs[v].rx_len; k++) rx_stream.push_back(rx_pool[vecs[v].rx_off + k]);
            apply_stimulus($sformatf("vec%0d", v), vecs[v].target, vecs[v].tx_chk, vecs[v].rx_start,
                           vecs[v].rx_in_send, vecs[v].exp_good, vecs[v].exp_nonce,
                           vecs[v].exp_chkerr, vecs[v].exp_evt);
        end
        last_nonce = 32'h0102_0304;

        // Reset in the middle of a command frame.
        tx_bytes.delete();
        n_valid = 0;
        n_timeout = 0;
        n_chkerr = 0;
        job_target = 32'h7777_0000;
        job_valid = 1'b1;
        tick();
        job_valid = 1'b0;
        guard = 0;
        while (tx_bytes.size() < 3 && guard < 200) begin
            tick();
            guard++;
        end
        rst_n = 1'b0;
        tick();
        check_output("midreset flags", {58'd0, job_ready, busy, new_tx_data, rsp_valid, rsp_timeout, rsp_chk_err},
                     64'b100000);
        check_output("midreset tx_data", 64'(tx_data), 64'd0);
        check_output("midreset rsp_nonce", 64'(rsp_nonce), 64'd0);
        check_output("midreset strobes", 64'(tx_bytes.size()), 64'd3);
        check_output("midreset pulses", 64'(n_valid + n_timeout + n_chkerr), 64'd0);
        rst_n = 1'b1;
        rx_stream.delete();
        for (int k = 0; k < 6; k++) rx_stream.push_back(rx_pool[k]);
        apply_stimulus("postreset", 32'h0000_00FF, 8'hFF, 2, 1'b0, 1'b1, 32'hDEAD_BEEF, 0, -1);
        last_nonce = 32'hDEAD_BEEF;

        // Randomized jobs against the reference model.
        for (int j = 0; j < 10; j++) begin
            int sc;
            t = $urandom;
            sc = $urandom_range(0, 3);
            rx_stream.delete();
            case (sc)
                0: begin
                    repeat ($urandom_range(0, 3)) begin
                        logic [7:0] g;
                        g = 8'($urandom_range(0, 255));
                        if (g == 8'hAA) g = 8'h00;
                        rx_stream.push_back(g);
                    end
                    push_frame($urandom, 1'b0);
                end
                1: begin
                    push_frame($urandom, 1'b1);
                    push_frame($urandom, 1'b0);
                end
                2: ;
                default: push_frame({8'hAA, 8'($urandom_range(0, 255)), 8'hAA, 8'($urandom_range(0, 255))}, 1'b0);
            endcase
            ref_model(m_good, m_nonce, m_err);
            if (m_good) last_nonce = m_nonce;
            apply_stimulus($sformatf("rand%0d", j), t, xor4(t), 2, 1'($urandom_range(0, 1)),
                           m_good, last_nonce, m_err, m_good ? -1 : TMO);
        end

        check_output("pulse overlap", 64'(n_overlap), 64'd0);
        check_output("pulse width", 64'(n_long), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
